xintf_master_if: RTL and testbench
==================================

Name: xintf_master_if

Overview:
- FPGA-side XINTF bus initiator. Runs single read or write cycles on an external asynchronous 16-bit XINTF slave.
- Strobe timing is programmable as lead, active and trail phases. Cycles are requested through a simple valid/ready command port.
- It is the counterpart of the existing DSP-facing XINTF-to-DPBRAM slave mux. It lets the FPGA act as bus master, toward a peer FPGA or in bench loopback against that mux.

Parameters:
- ADDR_WIDTH, 9, width of XA and the command address.
- DATA_WIDTH, 16, width of XD and the command/read data.
- LEAD_CYC, 2, clock cycles nCS is low before the strobe asserts. Legal range 1..255.
- ACTIVE_CYC, 4, clock cycles nWE or nRD is held low. Legal range 1..255.
- TRAIL_CYC, 1, clock cycles nCS stays low after the strobe deasserts. Legal range 1..255.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_cmd_valid  in  1  command request.
- i_cmd_wr  in  1  1 = write, 0 = read.
- i_cmd_addr  in  ADDR_WIDTH  target address.
- i_cmd_wdata  in  DATA_WIDTH  write data.
- o_cmd_ready  out  1  command can be accepted this cycle.
- o_busy  out  1  bus cycle in progress (LEAD/ACTIVE/TRAIL).
- o_rd_valid  out  1  one-cycle pulse; o_rd_data is valid.
- o_rd_data  out  DATA_WIDTH  captured read data; held until the next read.
- o_nZ_CS  out  1  chip select, active-low.
- o_nZ_WE  out  1  write strobe, active-low.
- o_nZ_RD  out  1  read strobe, active-low.
- o_Z_XA  out  ADDR_WIDTH  bus address.
- io_Z_XD  inout  DATA_WIDTH  bus data; tristate.

Behaviour:
- Reset (async, i_rst=1), taking effect immediately including mid-cycle:
  - State = IDLE.
  - o_nZ_CS, o_nZ_WE and o_nZ_RD = 1.
  - o_Z_XA = 0; io_Z_XD = Z.
  - o_cmd_ready = 0, o_busy = 0, o_rd_valid = 0, o_rd_data = 0.
  - An aborted cycle is dropped and never reported.
- o_cmd_ready = (state==IDLE) and not i_rst. The command is accepted on the edge where i_cmd_valid && o_cmd_ready. Address, data and wr are latched in that cycle.
- Command inputs are ignored whenever o_cmd_ready=0.
- State machine, with an 8-bit phase counter reloaded on each phase entry:
  - IDLE → LEAD on accept.
  - LEAD: LEAD_CYC cycles, then → ACTIVE.
  - ACTIVE: ACTIVE_CYC cycles, then → TRAIL.
  - TRAIL: TRAIL_CYC cycles, then → IDLE.
- Bus outputs are all registered, so they are glitch-free.
  - o_nZ_CS = 0 in LEAD, ACTIVE and TRAIL.
  - o_Z_XA = latched address in LEAD, ACTIVE and TRAIL; 0 in IDLE.
  - o_nZ_WE = 0 only in ACTIVE of a write; o_nZ_RD = 0 only in ACTIVE of a read. The two strobes are never low together.
- Data bus direction:
  - io_Z_XD is driven with the latched wdata from LEAD through TRAIL of a write.
  - It is Z in IDLE and during all phases of a read.
- Read capture:
  - io_Z_XD is sampled into o_rd_data on the clock edge ending the last ACTIVE cycle.
  - o_rd_valid = 1 for exactly the first TRAIL cycle.
- o_busy = (state != IDLE).
- Timing, with acceptance at cycle k:
  - LEAD occupies k+1..k+LEAD_CYC.
  - ACTIVE follows for ACTIVE_CYC cycles, then TRAIL for TRAIL_CYC cycles.
  - IDLE (o_cmd_ready=1) resumes at k+LEAD_CYC+ACTIVE_CYC+TRAIL_CYC+1.
  - nCS low width = LEAD_CYC+ACTIVE_CYC+TRAIL_CYC.
- Back-to-back commands: nCS is high for at least 1 cycle between bus cycles. That IDLE cycle is also the bus turnaround between a read and a following write.
- i_cmd_valid held high continuously gives one accept per IDLE cycle, i.e. the maximum rate.
- Parameter value 0 or >255 is illegal. The RTL must include an elaboration-time check that halts on it.

Test Plan:
- Write with defaults: cmd wr=1, addr=0x155, wdata=0xA5C3 accepted at cycle k.
  - nCS low k+1..k+7; nWE low k+3..k+6; nRD stays 1.
  - XA=0x155 and XD=0xA5C3 over k+1..k+7; XD=Z at k+8; o_cmd_ready=1 at k+8.
- Read with defaults: addr=0x003, slave drives XD=0x1234 while nRD is low.
  - nRD low k+3..k+6; o_rd_valid=1 only at k+7 with o_rd_data=0x1234.
  - o_rd_data still 0x1234 at k+20; XD never driven by the block.
- Back-to-back read then write with i_cmd_valid held high:
  - nCS high for exactly 1 cycle between the two bus cycles.
  - XD stays Z until the write's LEAD phase.
  - nWE and nRD are never low simultaneously.
- Parameter sweep LEAD/ACTIVE/TRAIL = 1/1/1 and 3/255/2: nCS width = 3 and 260; strobe width = 1 and 255.
- Reset mid-ACTIVE of a write:
  - nCS, nWE and nRD go to 1 and XD goes to Z within the same cycle, without waiting for a clock edge.
  - No o_rd_valid. After release, o_cmd_ready=1 on the first cycle and a fresh read completes normally.
- Loopback against the XINTF-to-DPBRAM slave mux: write 0xBEEF to addr 0x010, then read addr 0x010.
  - The mux's DPBRAM write port shows addr 0x010 and din 0xBEEF.
  - The read returns the DPBRAM output data presented on the bus.

Source files
------------

// File: rtl/xintf_master_if.sv
// xintf_master_if
//   FPGA-side XINTF bus initiator. Runs one read or write cycle at a time on an
//   external asynchronous 16-bit XINTF slave. Each cycle has three phases:
//   LEAD (nCS low, no strobe), ACTIVE (nWE or nRD low) and TRAIL (nCS low, no strobe).
//   The length of each phase is set at elaboration time.
//
// Ports
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_cmd_*           : command request (valid/wr/addr/wdata), accepted when o_cmd_ready
//   o_cmd_ready       : block is idle and can take a command this cycle
//   o_busy            : a bus cycle is in progress
//   o_rd_valid        : one-cycle pulse, o_rd_data holds fresh read data
//   o_rd_data         : last captured read data, held until the next read
//   o_nZ_CS/WE/RD     : active-low chip select / write strobe / read strobe (registered)
//   o_Z_XA            : bus address (registered, 0 while idle)
//   io_Z_XD           : tristate data bus, driven only during a write cycle
module xintf_master_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16,
    parameter int LEAD_CYC   = 2,
    parameter int ACTIVE_CYC = 4,
    parameter int TRAIL_CYC  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    input  logic                  i_cmd_wr,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                  o_cmd_ready,
    output logic                  o_busy,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_nZ_CS,
    output logic                  o_nZ_WE,
    output logic                  o_nZ_RD,
    output logic [ADDR_WIDTH-1:0] o_Z_XA,
    inout  wire  [DATA_WIDTH-1:0] io_Z_XD
);

    // Phase counters are 8 bits wide, so each phase must fit in 1..255 cycles.
    if (LEAD_CYC < 1 || LEAD_CYC > 255 ||
        ACTIVE_CYC < 1 || ACTIVE_CYC > 255 ||
        TRAIL_CYC < 1 || TRAIL_CYC > 255) begin : g_bad_timing
        $fatal(1, "xintf_master_if: LEAD/ACTIVE/TRAIL_CYC must be in 1..255");
    end

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LEAD   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_TRAIL  = 2'd3;

    localparam logic [7:0] LEAD_LD   = 8'(LEAD_CYC - 1);
    localparam logic [7:0] ACTIVE_LD = 8'(ACTIVE_CYC - 1);
    localparam logic [7:0] TRAIL_LD  = 8'(TRAIL_CYC - 1);

    logic [1:0]            state, state_nxt;
    logic [7:0]            cnt, cnt_nxt;
    logic                  last;
    logic                  accept;
    logic                  wr_q, wr_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  xd_oe;
    logic                  rd_done;

    assign o_cmd_ready = (state == ST_IDLE) && !i_rst;
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign o_busy      = (state != ST_IDLE);
    assign last        = (cnt == 8'd0);
    // Last ACTIVE cycle of a read: data is sampled on the edge that ends it.
    assign rd_done     = (state == ST_ACTIVE) && last && !wr_q;

    // Outputs are decoded from the next-cycle view so they can be registered
    // and still line up with the state they belong to.
    assign wr_nxt   = accept ? i_cmd_wr   : wr_q;
    assign addr_nxt = accept ? i_cmd_addr : addr_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_LEAD;
                    cnt_nxt   = LEAD_LD;
                end
            end
            ST_LEAD: begin
                if (last) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = ACTIVE_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            ST_ACTIVE: begin
                if (last) begin
                    state_nxt = ST_TRAIL;
                    cnt_nxt   = TRAIL_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                if (last) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            o_nZ_CS    <= 1'b1;
            o_nZ_WE    <= 1'b1;
            o_nZ_RD    <= 1'b1;
            o_Z_XA     <= '0;
            xd_oe      <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                wr_q    <= i_cmd_wr;
                addr_q  <= i_cmd_addr;
                wdata_q <= i_cmd_wdata;
            end
            o_nZ_CS    <= (state_nxt == ST_IDLE);
            o_nZ_WE    <= !((state_nxt == ST_ACTIVE) && wr_nxt);
            o_nZ_RD    <= !((state_nxt == ST_ACTIVE) && !wr_nxt);
            o_Z_XA     <= (state_nxt == ST_IDLE) ? '0 : addr_nxt;
            xd_oe      <= (state_nxt != ST_IDLE) && wr_nxt;
            o_rd_valid <= rd_done;
            if (rd_done) begin
                o_rd_data <= io_Z_XD;
            end
        end
    end

    assign io_Z_XD = xd_oe ? wdata_q : 'z;

endmodule

// File: tb/tb_xintf_master_if.sv
// Directed bench for xintf_master_if: a default-timing instance against a small
// XINTF slave model (with a bus keeper that pulls XD to 0 whenever the master
// must not be driving), plus two instances for the timing parameter sweep.
module tb_xintf_master_if;
    localparam int AW = 9;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // main instance
    logic          cmd_valid, cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_ready, busy, rd_valid;
    logic [DW-1:0] rd_data;
    logic          ncs, nwe, nrd;
    logic [AW-1:0] xa;
    wire  [DW-1:0] xd;

    // slave / keeper model
    logic          rd_mode, mem_mode;
    logic [DW-1:0] sval;
    logic [DW-1:0] mem [0:511];
    logic [AW-1:0] wp_addr;
    logic [DW-1:0] wp_din;
    wire           keep_oe = ncs | (rd_mode & nrd);
    assign xd = keep_oe ? 16'h0000 : 'z;
    assign xd = !nrd ? (mem_mode ? mem[xa] : sval) : 'z;

    always @(posedge clk) begin
        if (!ncs && !nwe) begin
            mem[xa] <= xd;
            wp_addr <= xa;
            wp_din  <= xd;
        end
    end

    xintf_master_if u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .i_cmd_wr(cmd_wr), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_cmd_ready(cmd_ready), .o_busy(busy), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
        .o_nZ_CS(ncs), .o_nZ_WE(nwe), .o_nZ_RD(nrd), .o_Z_XA(xa), .io_Z_XD(xd)
    );

    // sweep instances (write-only, nothing else on their buses)
    logic          sv1, sv2, sel;
    logic          rdy1, bsy1, rv1, ncs1, nwe1, nrd1;
    logic          rdy2, bsy2, rv2, ncs2, nwe2, nrd2;
    logic [DW-1:0] rdd1, rdd2;
    logic [AW-1:0] xa1, xa2;
    wire  [DW-1:0] xd1, xd2;
    wire           s_ncs = sel ? ncs2 : ncs1;
    wire           s_nwe = sel ? nwe2 : nwe1;
    wire  [DW-1:0] s_xd  = sel ? xd2 : xd1;

    xintf_master_if #(.LEAD_CYC(1), .ACTIVE_CYC(1), .TRAIL_CYC(1)) u_s1 (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(sv1), .i_cmd_wr(cmd_wr), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_cmd_ready(rdy1), .o_busy(bsy1), .o_rd_valid(rv1), .o_rd_data(rdd1),
        .o_nZ_CS(ncs1), .o_nZ_WE(nwe1), .o_nZ_RD(nrd1), .o_Z_XA(xa1), .io_Z_XD(xd1)
    );

    xintf_master_if #(.LEAD_CYC(3), .ACTIVE_CYC(255), .TRAIL_CYC(2)) u_s2 (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(sv2), .i_cmd_wr(cmd_wr), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
        .o_cmd_ready(rdy2), .o_busy(bsy2), .o_rd_valid(rv2), .o_rd_data(rdd2),
        .o_nZ_CS(ncs2), .o_nZ_WE(nwe2), .o_nZ_RD(nrd2), .o_Z_XA(xa2), .io_Z_XD(xd2)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] sval;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete default-timing transaction, entered and left at a negedge
    // of an idle cycle. Cycle offsets are relative to the accept cycle k.
    task automatic xact(input vec_t v, input string tag);
        logic [39:0] e, a;
        logic        cs_e, we_e, rd_e, rv_e;
        logic [DW-1:0] xd_e;
        chk({tag, " ready_k"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        sval = v.sval; rd_mode = !v.wr;
        @(negedge clk);
        // scramble command inputs: the block must use the latched values
        cmd_valid = 1'b0; cmd_wr = !v.wr; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
        for (int o = 1; o <= 8; o++) begin
            if (o > 1) @(negedge clk);
            cs_e = !(o <= 7);
            we_e = !(v.wr && o >= 3 && o <= 6);
            rd_e = !(!v.wr && o >= 3 && o <= 6);
            rv_e = (!v.wr && o == 7);
            if (v.wr && o <= 7)                   xd_e = v.wdata;
            else if (!v.wr && o >= 3 && o <= 6)   xd_e = v.sval;
            else                                  xd_e = 16'h0000;
            e = {cs_e, we_e, rd_e, rv_e, logic'(o <= 7), logic'(o >= 8),
                 (o <= 7) ? v.addr : 9'h000, xd_e};
            a = {ncs, nwe, nrd, rd_valid, busy, cmd_ready, xa, xd};
            chk($sformatf("%s wave k+%0d", tag, o), 64'(a), 64'(e));
        end
        chk({tag, " rd_data"}, 64'(rd_data), 64'(v.exp_rd));
    endtask

    task automatic sweep(input logic s, input int exp_cs, input int exp_st);
        int   cs_n = 0, st_n = 0;
        bit   seen = 0, done = 0, xd_ok = 1;
        sel = s;
        cmd_wr = 1'b1; cmd_addr = 9'h0C3; cmd_wdata = 16'h3C3C;
        if (s) sv2 = 1'b1; else sv1 = 1'b1;
        @(negedge clk);
        sv1 = 1'b0; sv2 = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            if (!s_ncs) begin
                seen = 1; cs_n++;
            end else if (seen) begin
                done = 1;
            end
            if (!done && !s_nwe) begin
                st_n++;
                if (s_xd !== 16'h3C3C) xd_ok = 0;
            end
            if (!done) @(negedge clk);
        end
        chk($sformatf("sweep%0d done", s), 64'(done), 64'd1);
        chk($sformatf("sweep%0d cs_width", s), 64'(cs_n), 64'(exp_cs));
        chk($sformatf("sweep%0d strobe_width", s), 64'(st_n), 64'(exp_st));
        chk($sformatf("sweep%0d xd", s), 64'(xd_ok), 64'd1);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        sv1 = 1'b0; sv2 = 1'b0; sel = 1'b0; rd_mode = 1'b0; mem_mode = 1'b0; sval = '0;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;

        //          wr    addr    wdata     slave     exp rd_data after
        vecs[0] = '{1'b1, 9'h155, 16'hA5C3, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 9'h003, 16'h0000, 16'h1234, 16'h1234};
        vecs[2] = '{1'b1, 9'h1FF, 16'hFFFF, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 9'h000, 16'h0000, 16'h0001, 16'h0001};
        vecs[4] = '{1'b0, 9'h0AA, 16'h0000, 16'hFFFF, 16'hFFFF};

        repeat (2) @(negedge clk);
        chk("reset state", 64'({ncs, nwe, nrd, rd_valid, busy, cmd_ready, xa, xd, rd_data}),
            64'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 16'h0000, 16'h0000}));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) xact(vecs[i], $sformatf("vec%0d", i));

        // read data held long after the read
        xact('{1'b0, 9'h003, 16'h0000, 16'h1234, 16'h1234}, "hold");
        repeat (12) @(negedge clk);
        chk("rd_data hold k+20", 64'(rd_data), 64'h1234);
        chk("rd_valid hold k+20", 64'(rd_valid), 64'd0);

        // back-to-back read then write with valid held high
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 9'h0A0; sval = 16'h4321; rd_mode = 1'b1;
        @(negedge clk);
        cmd_wr = 1'b1; cmd_addr = 9'h0A1; cmd_wdata = 16'h6E6E;
        for (int o = 1; o <= 16; o++) begin
            logic          cs_e, we_e, rd_e;
            logic [DW-1:0] xd_e;
            if (o > 1) @(negedge clk);
            if (o == 9) cmd_valid = 1'b0;
            cs_e = !((o >= 1 && o <= 7) || (o >= 9 && o <= 15));
            rd_e = !(o >= 3 && o <= 6);
            we_e = !(o >= 11 && o <= 14);
            if (o >= 3 && o <= 6)       xd_e = 16'h4321;
            else if (o >= 9 && o <= 15) xd_e = 16'h6E6E;
            else                        xd_e = 16'h0000;
            chk($sformatf("b2b k+%0d", o), 64'({ncs, nwe, nrd, (nwe | nrd), xd}),
                64'({cs_e, we_e, rd_e, 1'b1, xd_e}));
            if (o == 7) chk("b2b rd_valid", 64'({rd_valid, rd_data}), 64'({1'b1, 16'h4321}));
            if (o == 8) rd_mode = 1'b0;
        end

        // asynchronous reset in the middle of a write's ACTIVE phase
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 9'h0F0; cmd_wdata = 16'h5A5A; rd_mode = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst pre nwe", 64'({ncs, nwe, xd}), 64'({1'b0, 1'b0, 16'h5A5A}));
        #2 rst = 1'b1;
        #1;
        chk("rst async", 64'({ncs, nwe, nrd, xd, busy, cmd_ready, rd_valid}),
            64'({1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        chk("rst held", 64'({ncs, rd_valid, rd_data, xa}), 64'({1'b1, 1'b0, 16'h0000, 9'h000}));
        rst = 1'b0;
        #1;
        chk("rst release ready", 64'(cmd_ready), 64'd1);
        xact('{1'b0, 9'h011, 16'h0000, 16'h5678, 16'h5678}, "post_rst");

        // loopback against a DPBRAM-style slave
        mem_mode = 1'b1;
        xact('{1'b1, 9'h010, 16'hBEEF, 16'h0000, 16'h5678}, "lb_wr");
        chk("lb wport addr", 64'(wp_addr), 64'h010);
        chk("lb wport din", 64'(wp_din), 64'hBEEF);
        xact('{1'b0, 9'h010, 16'h0000, 16'hBEEF, 16'hBEEF}, "lb_rd");
        mem_mode = 1'b0;

        // timing parameter sweep
        sweep(1'b0, 3, 1);
        sweep(1'b1, 260, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
